bar_ram_arbiter: RTL and testbench
==================================

# bar_ram_arbiter

Shares one single-port bar-height RAM between two requesters. The display requester is the VGA-side scan logic, which fetches one bar height per bar column. The update requester is the Nios II-side spectrum writer, which stores new bar heights. Display reads have priority. A starvation counter guarantees forward progress for writes. All RAM-side signals are registered, so the block sits directly between the two requesters and the RAM macro.

## Interface
- NUM_BARS, default 64: number of bars, i.e. RAM depth.
- ADDR_W, default 6: address width; must satisfy 2**ADDR_W >= NUM_BARS.
- DATA_W, default 9: bar-height width (0..479 fits in 9 bits).
- STARVE_MAX, default 8: consecutive cycles a waiting write may lose before it is forced through; legal range 1..255.
- CLK  in  1  single clock for the whole block.
- RST  in  1  synchronous, active-high reset.
- rd_req  in  1  display read request; a read is accepted in any cycle where rd_req && rd_ready.
- rd_addr  in  ADDR_W  bar index to read; sampled on accept.
- rd_ready  out  1  low only while a deferred read is held.
- rd_valid  out  1  one-cycle pulse; rd_data is valid in that cycle.
- rd_data  out  DATA_W  read data.
- wr_req  in  1  update write request; held high, with wr_addr/wr_data stable, until wr_ack.
- wr_addr  in  ADDR_W  bar index to write.
- wr_data  in  DATA_W  new bar height.
- wr_ack  out  1  one-cycle pulse in the cycle the write reaches the RAM.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_we  out  1  registered RAM write enable.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_addr with ram_we=0.

## Operation
- Internal state:
  - hold_valid/hold_addr: one-entry deferred-read register.
  - starve_cnt: 8-bit counter.
  - rd_pend: 1-bit read-in-flight pipe.
- Grant decision, evaluated every cycle (cycle N), in priority order:
  1. hold_valid: issue the held read; hold_valid<=0. wr_req keeps waiting and starve_cnt increments if wr_req=1.
  2. rd_req && wr_req && starve_cnt==STARVE_MAX-1: issue the write and capture rd_addr into hold (hold_valid<=1). This counts as accepting the read. starve_cnt<=0.
  3. rd_req && wr_req otherwise: issue the read; starve_cnt<=starve_cnt+1.
  4. rd_req only: issue the read; starve_cnt<=0.
  5. wr_req only: issue the write; starve_cnt<=0.
  6. Neither: ram_we<=0, ram_addr holds; starve_cnt<=0.
- Issuing a read in cycle N: ram_addr<=address, ram_we<=0, rd_pend<=1.
- Issuing a write in cycle N: ram_addr<=wr_addr, ram_wdata<=wr_data, ram_we<=1. wr_ack is asserted in N+1, when ram_we is high.
- wr_req seen in the cycle wr_ack is high is a new request; the requester must drop or change it that cycle. The block never grants the same write twice: a write granted in N is not eligible in N+1.
- rd_ready = !hold_valid (combinational).
- rd_data = ram_rdata passthrough. rd_valid = registered rd_pend.
- Ordering: when a write and a same-address read collide, the write is issued first, so the deferred read returns the new data. A normally granted read returns the old data.
- starve_cnt saturates at STARVE_MAX-1 and never wraps.

## Timing
- Read latency, accept to rd_valid:
  - 2 cycles normally (N: accept, N+1: ram_addr driven, N+2: rd_valid).
  - 3 cycles when deferred.
- Write latency: wr_ack 1 cycle after grant. Worst-case wait from wr_req to grant under continuous reads is STARVE_MAX cycles.
- Throughput: one RAM access per cycle. Reads are back-to-back except for one bubble on rd_ready after each forced write.
- Reset, synchronous on CLK when RST=1, values visible the cycle after:
  - hold_valid=0, rd_pend=0, starve_cnt=0.
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - rd_valid=0, wr_ack=0, rd_ready=1.
- RST mid-operation: in-flight reads and writes are dropped with no rd_valid or wr_ack. A write already presented to the RAM (ram_we=1 in the RST cycle) completes at the RAM; the requester must reissue after reset.

## Test plan
- Idle reads: after RST, write addr 5 = 300 with no reads. Expect wr_ack 1 cycle later. Then read addr 5: rd_valid 2 cycles after accept with rd_data=300.
- Starvation: STARVE_MAX=8, rd_req held high on incrementing addresses, wr_req raised (addr 3 = 17).
  - Expect 7 reads granted, write granted on the 8th cycle, wr_ack the next cycle.
  - rd_ready low exactly one cycle; the deferred read returns at latency 3.
- Collision ordering: force a write of addr 9 = 100 over a read of addr 9 (old value 50). Expect the deferred read to return 100. The unforced case returns 50.
- Back-to-back writes: wr_req held for 3 sequential writes with no reads. Expect ram_we high on 3 consecutive grants separated as specified, one wr_ack per write, and no duplicate write.
- Mid-operation reset: assert RST one cycle after a read accept. Expect no rd_valid, rd_ready=1, starve_cnt=0, and normal operation after RST deasserts.
- Saturation: STARVE_MAX=1 with continuous reads and writes. Expect the write forced on every eligible cycle, the hold drained each following cycle, and no read lost: rd_valid count equals accepted reads.

Source files
------------

// File: rtl/bar_ram_arbiter.sv
// Arbitrates one single-port bar-height RAM between display reads (priority) and update writes.
// A starvation counter forces a waiting write through, deferring the colliding read by one slot.
module bar_ram_arbiter #(
    parameter int unsigned NUM_BARS   = 64,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    if (((1 << ADDR_W) < NUM_BARS) || (STARVE_MAX < 1) || (STARVE_MAX > 255)) begin : g_bad_params
        $error("bar_ram_arbiter: illegal parameter combination");
    end

    localparam logic [7:0] STARVE_TOP = 8'(STARVE_MAX - 1);

    typedef enum logic [2:0] {
        GrNone,
        GrHold,
        GrForce,
        GrRead,
        GrWrite
    } grant_e;

    logic              hold_valid;
    logic [ADDR_W-1:0] hold_addr;
    logic [7:0]        starve_cnt;
    logic              rd_pend;

    grant_e            grant;
    logic              wr_elig;
    logic [7:0]        starve_inc;
    logic [7:0]        starve_next;

    always_comb begin
        // The write acked this cycle was granted last cycle; never grant it again.
        wr_elig    = wr_req && !wr_ack;
        starve_inc = (starve_cnt == STARVE_TOP) ? starve_cnt : starve_cnt + 8'd1;

        grant = GrNone;
        if (hold_valid) begin
            grant = GrHold;
        end else if (rd_req && wr_elig && (starve_cnt == STARVE_TOP)) begin
            grant = GrForce;
        end else if (rd_req) begin
            grant = GrRead;
        end else if (wr_elig) begin
            grant = GrWrite;
        end

        starve_next = 8'd0;
        if ((grant == GrHold || grant == GrRead) && wr_elig) begin
            starve_next = starve_inc;
        end
    end

    assign rd_ready = !hold_valid;
    assign rd_data  = ram_rdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            starve_cnt <= 8'd0;
            rd_pend    <= 1'b0;
            rd_valid   <= 1'b0;
            wr_ack     <= 1'b0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
        end else begin
            rd_valid   <= rd_pend;
            wr_ack     <= (grant == GrForce) || (grant == GrWrite);
            starve_cnt <= starve_next;
            unique case (grant)
                GrHold: begin
                    ram_addr   <= hold_addr;
                    ram_we     <= 1'b0;
                    rd_pend    <= 1'b1;
                    hold_valid <= 1'b0;
                end
                GrForce: begin
                    // Write goes first so a same-address deferred read sees the new value.
                    ram_addr   <= wr_addr;
                    ram_wdata  <= wr_data;
                    ram_we     <= 1'b1;
                    rd_pend    <= 1'b0;
                    hold_valid <= 1'b1;
                    hold_addr  <= rd_addr;
                end
                GrRead: begin
                    ram_addr <= rd_addr;
                    ram_we   <= 1'b0;
                    rd_pend  <= 1'b1;
                end
                GrWrite: begin
                    ram_addr  <= wr_addr;
                    ram_wdata <= wr_data;
                    ram_we    <= 1'b1;
                    rd_pend   <= 1'b0;
                end
                default: begin
                    ram_we  <= 1'b0;
                    rd_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bar_ram_arbiter.sv
// Directed bench for bar_ram_arbiter: two instances (STARVE_MAX 8 and 1), each with a RAM model
// and a read scoreboard that checks data and arrival cycle of every rd_valid.
module tb_bar_ram_arbiter;

    logic CLK;
    logic RST;
    logic preload;
    int   cyc;
    int   total;
    int   bad;

    typedef struct packed {
        logic [8:0]  data;
        logic [31:0] due;
    } exp_t;

    // Instance A: STARVE_MAX = 8
    logic       rd_req_a, rd_ready_a, rd_valid_a, wr_req_a, wr_ack_a, ram_we_a;
    logic [5:0] rd_addr_a, wr_addr_a, ram_addr_a;
    logic [8:0] rd_data_a, wr_data_a, ram_wdata_a, ram_rdata_a;
    logic [8:0] mem_a [64];
    exp_t       q_a [$];
    exp_t       e_a;

    // Instance B: STARVE_MAX = 1
    logic       rd_req_b, rd_ready_b, rd_valid_b, wr_req_b, wr_ack_b, ram_we_b;
    logic [5:0] rd_addr_b, wr_addr_b, ram_addr_b;
    logic [8:0] rd_data_b, wr_data_b, ram_wdata_b, ram_rdata_b;
    logic [8:0] mem_b [64];
    exp_t       q_b [$];
    exp_t       e_b;
    int         rv_b_cnt;
    int         wa_b_cnt;

    bar_ram_arbiter #(
        .NUM_BARS  (64),
        .ADDR_W    (6),
        .DATA_W    (9),
        .STARVE_MAX(8)
    ) dut_a (
        .CLK      (CLK),
        .RST      (RST),
        .rd_req   (rd_req_a),
        .rd_addr  (rd_addr_a),
        .rd_ready (rd_ready_a),
        .rd_valid (rd_valid_a),
        .rd_data  (rd_data_a),
        .wr_req   (wr_req_a),
        .wr_addr  (wr_addr_a),
        .wr_data  (wr_data_a),
        .wr_ack   (wr_ack_a),
        .ram_addr (ram_addr_a),
        .ram_we   (ram_we_a),
        .ram_wdata(ram_wdata_a),
        .ram_rdata(ram_rdata_a)
    );

    bar_ram_arbiter #(
        .NUM_BARS  (64),
        .ADDR_W    (6),
        .DATA_W    (9),
        .STARVE_MAX(1)
    ) dut_b (
        .CLK      (CLK),
        .RST      (RST),
        .rd_req   (rd_req_b),
        .rd_addr  (rd_addr_b),
        .rd_ready (rd_ready_b),
        .rd_valid (rd_valid_b),
        .rd_data  (rd_data_b),
        .wr_req   (wr_req_b),
        .wr_addr  (wr_addr_b),
        .wr_data  (wr_data_b),
        .wr_ack   (wr_ack_b),
        .ram_addr (ram_addr_b),
        .ram_we   (ram_we_b),
        .ram_wdata(ram_wdata_b),
        .ram_rdata(ram_rdata_b)
    );

    function automatic logic [8:0] pat(input logic [5:0] a);
        return 9'(a) * 9'd7 + 9'd2;
    endfunction

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous-read RAM models, one cycle read latency.
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= pat(6'(i));
        end else if (ram_we_a) begin
            mem_a[ram_addr_a] <= ram_wdata_a;
        end
        ram_rdata_a <= mem_a[ram_addr_a];
    end

    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_b[i] <= pat(6'(i));
        end else if (ram_we_b) begin
            mem_b[ram_addr_b] <= ram_wdata_b;
        end
        ram_rdata_b <= mem_b[ram_addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_a(input logic [8:0] d, input int lat);
        q_a.push_back('{data: d, due: 32'(cyc + lat)});
    endtask

    task automatic push_b(input logic [8:0] d, input int lat);
        q_b.push_back('{data: d, due: 32'(cyc + lat)});
    endtask

    // Scoreboards: pop on rd_valid, flag overdue entries so a lost read cannot hang the bench.
    always @(negedge CLK) begin
        if (rd_valid_a === 1'b1) begin
            if (q_a.size() == 0) begin
                chk("a_rd_extra", 32'd1, 32'd0);
            end else begin
                e_a = q_a.pop_front();
                chk("a_rd_data", 32'(rd_data_a), 32'(e_a.data));
                chk("a_rd_lat", 32'(cyc), e_a.due);
            end
        end else if (q_a.size() != 0 && 32'(cyc) > q_a[0].due) begin
            chk("a_rd_missing", 32'd0, 32'd1);
            void'(q_a.pop_front());
        end
    end

    always @(negedge CLK) begin
        if (wr_ack_b === 1'b1) wa_b_cnt++;
        if (rd_valid_b === 1'b1) begin
            rv_b_cnt++;
            if (q_b.size() == 0) begin
                chk("b_rd_extra", 32'd1, 32'd0);
            end else begin
                e_b = q_b.pop_front();
                chk("b_rd_data", 32'(rd_data_b), 32'(e_b.data));
                chk("b_rd_lat", 32'(cyc), e_b.due);
            end
        end else if (q_b.size() != 0 && 32'(cyc) > q_b[0].due) begin
            chk("b_rd_missing", 32'd0, 32'd1);
            void'(q_b.pop_front());
        end
    end

    task automatic do_write_a(input logic [5:0] a, input logic [8:0] d);
        wr_req_a  = 1'b1;
        wr_addr_a = a;
        wr_data_a = d;
        tick();
        chk("wr_ack", 32'(wr_ack_a), 32'd1);
        chk("wr_ram_we", 32'(ram_we_a), 32'd1);
        chk("wr_ram_addr", 32'(ram_addr_a), 32'(a));
        chk("wr_ram_wdata", 32'(ram_wdata_a), 32'(d));
        wr_req_a = 1'b0;
        tick();
        chk("wr_ack_drop", 32'(wr_ack_a), 32'd0);
    endtask

    task automatic do_read_a(input logic [5:0] a, input logic [8:0] d);
        rd_req_a  = 1'b1;
        rd_addr_a = a;
        chk("rd_ready_idle", 32'(rd_ready_a), 32'd1);
        push_a(d, 2);
        tick();
        rd_req_a = 1'b0;
        repeat (3) tick();
    endtask

    // Continuous reads with one waiting write; write is forced in cycle 7, read deferred.
    task automatic starve_run(input logic [5:0] wa, input logic [8:0] wd, input logic [5:0] base,
                              input bit collide, input logic [8:0] old);
        logic [5:0] a;
        logic [8:0] d;
        wr_req_a  = 1'b1;
        wr_addr_a = wa;
        wr_data_a = wd;
        rd_req_a  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            a = base + 6'(k);
            d = pat(a);
            if (collide && k == 0) begin
                a = wa;
                d = old;
            end
            if (collide && k == 7) begin
                a = wa;
                d = wd;
            end
            rd_addr_a = a;
            chk("st_rd_ready", 32'(rd_ready_a), (k == 8) ? 32'd0 : 32'd1);
            if (k != 8) push_a(d, (k == 7) ? 3 : 2);
            tick();
            chk("st_wr_ack", 32'(wr_ack_a), (k == 7) ? 32'd1 : 32'd0);
            if (k == 7) begin
                chk("st_ram_we", 32'(ram_we_a), 32'd1);
                chk("st_ram_addr", 32'(ram_addr_a), 32'(wa));
                wr_req_a = 1'b0;
            end
        end
        rd_req_a = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        int         acc;
        logic [5:0] j;
        total     = 0;
        bad       = 0;
        rv_b_cnt  = 0;
        wa_b_cnt  = 0;
        RST       = 1'b1;
        preload   = 1'b1;
        rd_req_a  = 1'b0; rd_addr_a = '0; wr_req_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        rd_req_b  = 1'b0; rd_addr_b = '0; wr_req_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        repeat (3) tick();
        RST     = 1'b0;
        preload = 1'b0;

        chk("rst_rd_ready", 32'(rd_ready_a), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid_a), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack_a), 32'd0);
        chk("rst_ram_we", 32'(ram_we_a), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr_a), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata_a), 32'd0);
        chk("rst_starve", 32'(dut_a.starve_cnt), 32'd0);
        tick();

        // Idle write then read back.
        do_write_a(6'd5, 9'd300);
        do_read_a(6'd5, 9'd300);
        do_write_a(6'd9, 9'd50);

        // Starvation: 7 reads win, write forced on the 8th, deferred read latency 3.
        starve_run(6'd3, 9'd17, 6'd10, 1'b0, 9'd0);
        do_read_a(6'd3, 9'd17);

        // Collision: unforced read of 9 returns 50, forced-over read of 9 returns 100.
        starve_run(6'd9, 9'd100, 6'd30, 1'b1, 9'd50);

        // Back-to-back writes: a write is never eligible in its own ack cycle.
        wr_req_a  = 1'b1;
        wr_addr_a = 6'd40;
        wr_data_a = 9'd400;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_ack", 32'(wr_ack_a), 32'd1);
            chk("b2b_we", 32'(ram_we_a), 32'd1);
            chk("b2b_addr", 32'(ram_addr_a), 32'(40 + i));
            chk("b2b_wdata", 32'(ram_wdata_a), 32'(400 + i));
            if (i == 2) begin
                wr_req_a = 1'b0;
            end else begin
                wr_addr_a = 6'(41 + i);
                wr_data_a = 9'(401 + i);
            end
            tick();
            chk("b2b_ack_gap", 32'(wr_ack_a), 32'd0);
            chk("b2b_we_gap", 32'(ram_we_a), 32'd0);
        end
        do_read_a(6'd40, 9'd400);
        do_read_a(6'd41, 9'd401);
        do_read_a(6'd42, 9'd402);

        // Mid-operation reset one cycle after a read accept: the read is dropped.
        rd_req_a  = 1'b1;
        rd_addr_a = 6'd5;
        wr_req_a  = 1'b1;
        wr_addr_a = 6'd50;
        wr_data_a = 9'd7;
        tick();
        chk("mr_starve_pre", 32'(dut_a.starve_cnt), 32'd1);
        rd_req_a = 1'b0;
        wr_req_a = 1'b0;
        RST      = 1'b1;
        tick();
        RST = 1'b0;
        chk("mr_rd_valid", 32'(rd_valid_a), 32'd0);
        chk("mr_rd_ready", 32'(rd_ready_a), 32'd1);
        chk("mr_wr_ack", 32'(wr_ack_a), 32'd0);
        chk("mr_starve", 32'(dut_a.starve_cnt), 32'd0);
        tick();
        chk("mr_rd_valid2", 32'(rd_valid_a), 32'd0);
        do_read_a(6'd5, 9'd300);

        // Saturation with STARVE_MAX=1: every other cycle is a forced write, the next drains hold.
        acc      = 0;
        j        = 6'd0;
        rd_req_b = 1'b1;
        wr_req_b = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 1) j = j + 6'd1;
            rd_addr_b = 6'(k);
            wr_addr_b = 6'd40 + j;
            wr_data_b = 9'd100 + 9'(j);
            chk("sat_rd_ready", 32'(rd_ready_b), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("sat_wr_ack", 32'(wr_ack_b), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 0) begin
                push_b(pat(6'(k)), 3);
                acc++;
            end
            tick();
        end
        rd_req_b = 1'b0;
        wr_req_b = 1'b0;
        repeat (6) tick();
        chk("sat_rd_count", 32'(rv_b_cnt), 32'(acc));
        chk("sat_wr_count", 32'(wa_b_cnt), 32'd10);
        chk("sat_mem_last", 32'(mem_b[49]), 32'd109);

        chk("q_a_empty", 32'(q_a.size()), 32'd0);
        chk("q_b_empty", 32'(q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
